// File: rtl/n64_cfg_mailbox_if.sv
// ============================================================================
// Module      : n64_cfg_mailbox_if
// Description : N64 PI-style halfword access bus between the front-end
//               decoder (master) and the config mailbox (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface n64_cfg_mailbox_if;
    logic        n64_request;
    logic        n64_write;
    logic [3:0]  n64_address;
    logic [15:0] n64_wdata;
    logic [15:0] n64_rdata;
    logic        n64_ack;

    modport master (
        output n64_request, n64_write, n64_address, n64_wdata,
        input  n64_rdata, n64_ack
    );

    modport slave (
        input  n64_request, n64_write, n64_address, n64_wdata,
        output n64_rdata, n64_ack
    );
endinterface

`default_nettype wire

// File: rtl/n64_cfg_mailbox.sv
// ============================================================================
// Module      : n64_cfg_mailbox
// Description : N64-side config command mailbox. Assembles 32-bit register
//               writes from halfword accesses, issues command pulses to the
//               CPU side and mirrors status/data words back to the N64.
//               Optional macro N64_CFG_IRQ_EN enables the completion irq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module n64_cfg_mailbox #(
    parameter logic [31:0] VERSION     = 32'h53437632,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                reset,
    n64_cfg_mailbox_if.slave    bus,
    input  logic                cpu_ready,
    input  logic                cpu_busy,
    input  logic                cmd_error,
    input  logic [31:0]         cpu_wdata,
    input  logic [1:0]          cpu_data_write,
    output logic [7:0]          cmd,
    output logic                cmd_request,
    output logic [31:0]         data_0,
    output logic [31:0]         data_1,
    output logic                irq
);

    localparam logic [2:0] c_WAIT_LOAD = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic        r_write;
    logic [3:1]  r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_hold_hi;
    logic [15:0] r_rd_latch;
    logic [1:0]  r_rd_idx;
    logic        r_rd_valid;
    logic [7:0]  r_cmd;
    logic        r_cmd_dropped;
    logic        r_inflight;
    logic [31:0] r_data_0, r_data_1;
    logic        w_irq_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.n64_request) begin
                    w_state_nxt    = (c_WAIT_LOAD == 3'd0) ? S_ACK : S_WAIT;
                    w_wait_cnt_nxt = c_WAIT_LOAD;
                end
            end
            S_WAIT: begin
                w_wait_cnt_nxt = r_wait_cnt - 3'd1;
                if (r_wait_cnt <= 3'd1) begin
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    logic        w_accept, w_ack, w_odd;
    logic [1:0]  w_reg;
    logic [31:0] w_commit_val, w_scr, w_live;
    logic        w_wr_commit, w_wr_even, w_rd_even, w_rd_odd;
    logic        w_scr_commit, w_cmd_ok, w_cmd_accept, w_cmd_reject;
    logic        w_data_ok, w_d0_commit, w_d1_commit;
    logic [15:0] w_rdata;

    assign w_accept     = (r_state == S_IDLE) && bus.n64_request;
    assign w_ack        = (r_state == S_ACK);
    assign w_reg        = r_addr[3:2];
    assign w_odd        = r_addr[1];
    assign w_commit_val = {r_hold_hi, r_wdata};

    assign w_wr_commit  = w_ack &  r_write &  w_odd;
    assign w_wr_even    = w_ack &  r_write & ~w_odd;
    assign w_rd_even    = w_ack & ~r_write & ~w_odd;
    assign w_rd_odd     = w_ack & ~r_write &  w_odd;

    assign w_scr_commit = w_wr_commit & (w_reg == 2'd0);
    assign w_cmd_ok     = cpu_ready & ~cpu_busy & ~r_inflight;
    assign w_cmd_accept = w_scr_commit &  w_cmd_ok;
    assign w_cmd_reject = w_scr_commit & ~w_cmd_ok;

    assign w_data_ok    = ~cpu_busy & ~r_inflight;
    assign w_d0_commit  = w_wr_commit & (w_reg == 2'd1) & w_data_ok;
    assign w_d1_commit  = w_wr_commit & (w_reg == 2'd2) & w_data_ok;

    assign w_scr = {cpu_ready, cpu_busy, w_irq_pending, cmd_error, r_cmd_dropped,
                    19'd0, r_cmd};

    always_comb begin
        w_live = w_scr;
        case (w_reg)
            2'd1:    w_live = r_data_0;
            2'd2:    w_live = r_data_1;
            2'd3:    w_live = VERSION;
            default: w_live = w_scr;
        endcase
    end

    // An odd read returns the half snapshotted by the preceding even read of the same register.
    always_comb begin
        w_rdata = 16'd0;
        if (w_ack && !r_write) begin
            if (!w_odd) begin
                w_rdata = w_live[31:16];
            end else if (r_rd_valid && (r_rd_idx == w_reg)) begin
                w_rdata = r_rd_latch;
            end else begin
                w_rdata = w_live[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write       <= 1'b0;
            r_addr        <= 3'd0;
            r_wdata       <= 16'd0;
            r_hold_hi     <= 16'd0;
            r_rd_latch    <= 16'd0;
            r_rd_idx      <= 2'd0;
            r_rd_valid    <= 1'b0;
            r_cmd         <= 8'd0;
            r_cmd_dropped <= 1'b0;
            r_inflight    <= 1'b0;
            r_data_0      <= 32'd0;
            r_data_1      <= 32'd0;
        end else begin
            if (w_accept) begin
                r_write <= bus.n64_write;
                r_addr  <= bus.n64_address[3:1];
                r_wdata <= bus.n64_wdata;
            end
            if (w_wr_even) begin
                r_hold_hi <= r_wdata;
            end
            if (w_rd_even) begin
                r_rd_latch <= w_live[15:0];
                r_rd_idx   <= w_reg;
                r_rd_valid <= 1'b1;
            end else if (w_rd_odd) begin
                r_rd_valid <= 1'b0;
            end
            if (w_cmd_accept) begin
                r_cmd <= r_wdata[7:0];
            end
            if (w_cmd_reject) begin
                r_cmd_dropped <= 1'b1;
            end else if (w_scr_commit && w_commit_val[27]) begin
                r_cmd_dropped <= 1'b0;
            end
            // Covers the gap between issuing a command and the CPU raising busy.
            if (cpu_busy) begin
                r_inflight <= 1'b0;
            end else if (w_cmd_accept) begin
                r_inflight <= 1'b1;
            end
            if (cpu_data_write[0]) begin
                r_data_0 <= cpu_wdata;
            end else if (w_d0_commit) begin
                r_data_0 <= w_commit_val;
            end
            if (cpu_data_write[1]) begin
                r_data_1 <= cpu_wdata;
            end else if (w_d1_commit) begin
                r_data_1 <= w_commit_val;
            end
        end
    end

`ifdef N64_CFG_IRQ_EN
    logic r_busy_q;
    logic r_irq_pending;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_q      <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_busy_q <= cpu_busy;
            if (r_busy_q && !cpu_busy) begin
                r_irq_pending <= 1'b1;
            end else if (w_scr_commit && w_commit_val[29]) begin
                r_irq_pending <= 1'b0;
            end
        end
    end

    assign w_irq_pending = r_irq_pending;
`else
    assign w_irq_pending = 1'b0;
`endif

    assign bus.n64_rdata = w_rdata;
    assign bus.n64_ack   = w_ack;
    assign cmd           = r_cmd;
    assign cmd_request   = w_cmd_accept;
    assign data_0        = r_data_0;
    assign data_1        = r_data_1;
    assign irq           = w_irq_pending;

endmodule

`default_nettype wire

// File: tb/tb_n64_cfg_mailbox.sv
// ============================================================================
// Module      : tb_n64_cfg_mailbox
// Description : Scoreboard bench for n64_cfg_mailbox; read expectations are
//               queued by the driver and checked by a monitor on n64_ack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_n64_cfg_mailbox;

    localparam int unsigned WS = 1;
`ifdef N64_CFG_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_ready, cpu_busy, cmd_error;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_data_write;
    logic [7:0]  cmd;
    logic        cmd_request;
    logic [31:0] data_0, data_1;
    logic        irq;

    n64_cfg_mailbox_if bus ();

    n64_cfg_mailbox #(
        .VERSION     (32'h53437632),
        .WAIT_STATES (WS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .cpu_ready      (cpu_ready),
        .cpu_busy       (cpu_busy),
        .cmd_error      (cmd_error),
        .cpu_wdata      (cpu_wdata),
        .cpu_data_write (cpu_data_write),
        .cmd            (cmd),
        .cmd_request    (cmd_request),
        .data_0         (data_0),
        .data_1         (data_1),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulses = 0;

    logic [16:0] sb_q[$];
    string       name_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per ack, counts command pulses.
    always @(negedge clk) begin
        logic [16:0] e;
        string       nm;
        if (cmd_request === 1'b1) begin
            pulses++;
        end
        if (bus.n64_ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_ack", 32'd1, 32'd0);
            end else begin
                e  = sb_q.pop_front();
                nm = name_q.pop_front();
                if (e[16]) begin
                    check(nm, {16'd0, bus.n64_rdata}, {16'd0, e[15:0]});
                end
            end
        end
    end

    task automatic access(input string nm, input logic wr, input logic [3:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp,
                          input logic [1:0] strobe, input logic [31:0] swd,
                          input logic chk_lat);
        int   n;
        logic got;
        sb_q.push_back({~wr, exp});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        bus.n64_request = 1'b1;
        bus.n64_write   = wr;
        bus.n64_address = addr;
        bus.n64_wdata   = wd;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.n64_ack === 1'b1) got = 1'b1;
        end
        if (!got) begin
            check({nm, "_ack_timeout"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
            void'(name_q.pop_front());
        end else begin
            if (chk_lat) check({nm, "_latency"}, 32'(n - 1), 32'(WS + 1));
            if (strobe != 2'b00) begin
                cpu_data_write = strobe;
                cpu_wdata      = swd;
            end
        end
        @(posedge clk);
        #1;
        bus.n64_request = 1'b0;
        cpu_data_write  = 2'b00;
    endtask

    task automatic rd(input string nm, input logic [3:0] addr, input logic [15:0] exp);
        access(nm, 1'b0, addr, 16'd0, exp, 2'b00, 32'd0, 1'b0);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [15:0] wd);
        access("write", 1'b1, addr, wd, 16'd0, 2'b00, 32'd0, 1'b0);
    endtask

    task automatic busy_pulse(input int cycles);
        @(posedge clk);
        #1 cpu_busy = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 cpu_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack_seen;
        reset           = 1'b1;
        bus.n64_request = 1'b0;
        bus.n64_write   = 1'b0;
        bus.n64_address = 4'd0;
        bus.n64_wdata   = 16'd0;
        cpu_ready       = 1'b0;
        cpu_busy        = 1'b0;
        cmd_error       = 1'b0;
        cpu_wdata       = 32'd0;
        cpu_data_write  = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'd0, bus.n64_ack}, 32'd0);
        check("rst_rdata", {16'd0, bus.n64_rdata}, 32'd0);
        check("rst_cmd", {24'd0, cmd}, 32'd0);
        check("rst_data", {data_0 | data_1}, 32'd0);
        check("rst_irq_req", {30'd0, irq, cmd_request}, 32'd0);

        access("ver_hi", 1'b0, 4'hC, 16'd0, 16'h5343, 2'b00, 32'd0, 1'b1);
        access("ver_lo", 1'b0, 4'hE, 16'd0, 16'h7632, 2'b00, 32'd0, 1'b1);

        cpu_ready = 1'b1;
        wr(4'h0, 16'h0000);
        wr(4'h2, 16'h0052);
        check("cmd_first", {24'd0, cmd}, 32'h52);
        check("pulses_first", 32'(pulses), 32'd1);

        wr(4'h0, 16'h0000);
        wr(4'h2, 16'h0033);
        check("cmd_rejected_keeps", {24'd0, cmd}, 32'h52);
        check("pulses_rejected", 32'(pulses), 32'd1);
        rd("scr_hi_dropped", 4'h0, 16'h8800);
        rd("scr_lo_cmd", 4'h2, 16'h0052);

        busy_pulse(2);
        check("irq_after_busy_fall", {31'd0, irq}, {31'd0, IRQ_ON});

        wr(4'h0, 16'h2800);
        wr(4'h2, 16'h0077);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        check("cmd_second", {24'd0, cmd}, 32'h77);
        check("pulses_second", 32'(pulses), 32'd2);
        rd("scr_hi_clear", 4'h0, 16'h8000);
        rd("scr_lo_cmd2", 4'h2, 16'h0077);

        busy_pulse(1);
        wr(4'h8, 16'hCAFE);
        wr(4'hA, 16'hF00D);
        check("data1_n64", data_1, 32'hCAFEF00D);

        wr(4'h4, 16'hDEAD);
        access("write", 1'b1, 4'h6, 16'hBEEF, 16'd0, 2'b01, 32'h12345678, 1'b0);
        check("data0_cpu_wins", data_0, 32'h12345678);
        check("data1_untouched", data_1, 32'hCAFEF00D);

        wr(4'h4, 16'h1111);
        access("write", 1'b1, 4'h6, 16'h2222, 16'd0, 2'b10, 32'h0BADF00D, 1'b0);
        check("data0_other_strobe", data_0, 32'h11112222);
        check("data1_cpu_write", data_1, 32'h0BADF00D);

        cpu_busy = 1'b1;
        wr(4'h4, 16'h3333);
        wr(4'h6, 16'h4444);
        check("data0_busy_ignored", data_0, 32'h11112222);
        cpu_busy = 1'b0;
        repeat (2) @(posedge clk);

        rd("d1_hi_snap", 4'h8, 16'h0BAD);
        @(posedge clk);
        #1 cpu_data_write = 2'b10; cpu_wdata = 32'hAAAA5555;
        @(posedge clk);
        #1 cpu_data_write = 2'b00;
        check("data1_cpu_live", data_1, 32'hAAAA5555);
        rd("d1_lo_latched", 4'hA, 16'hF00D);
        rd("d1_lo_live", 4'hA, 16'h5555);
        rd("d0_hi_snap", 4'h4, 16'h1111);
        rd("d1_lo_idx_mismatch", 4'hA, 16'h5555);

        ack_seen = 0;
        @(posedge clk);
        #1 bus.n64_request = 1'b1; bus.n64_write = 1'b0; bus.n64_address = 4'hC;
        @(posedge clk);
        #1 reset = 1'b1; bus.n64_request = 1'b0;
        @(negedge clk);
        if (bus.n64_ack === 1'b1) ack_seen++;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        if (bus.n64_ack === 1'b1) ack_seen++;
        check("post_rst_rdata", {16'd0, bus.n64_rdata}, 32'd0);
        check("post_rst_cmd", {24'd0, cmd}, 32'd0);
        check("post_rst_data0", data_0, 32'd0);
        check("post_rst_data1", data_1, 32'd0);
        check("post_rst_irq_req", {30'd0, irq, cmd_request}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (bus.n64_ack === 1'b1) ack_seen++;
        end
        check("aborted_no_ack", 32'(ack_seen), 32'd0);
        check("pulses_final", 32'(pulses), 32'd2);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/n64_cfg_mailbox.md
Name: n64_cfg_mailbox

Overview:
- N64-side end of the configuration command mailbox.
- Accepts 16-bit PI-style halfword accesses from the N64 bus front-end, assembles 32-bit register writes, and issues single-cycle command requests to the CPU-side config block.
- Mirrors CPU status (ready/busy/error) and the two shared data words back to the N64.
- Sits between the N64 PI decoder and the config interface. The CPU side writes data words through this block's CPU write port.

Parameters:
- VERSION, 32'h53437632, value returned by the VERSION register.
- WAIT_STATES, 1, extra cycles between request acceptance and n64_ack (0..7).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- n64_request  in  1  access request, held high until n64_ack
- n64_write  in  1  1=write, 0=read; stable while n64_request is high
- n64_address  in  4  byte address; [3:2] selects the register, [1] selects the halfword (0 = bits 31:16)
- n64_wdata  in  16  write halfword
- n64_rdata  out  16  read halfword, valid only while n64_ack is high
- n64_ack  out  1  single-cycle access completion
- cpu_ready  in  1  CPU status
- cpu_busy  in  1  CPU status
- cmd_error  in  1  CPU status
- cpu_wdata  in  32  CPU write data for data words
- cpu_data_write  in  2  per-word CPU write strobe
- cmd  out  8  last accepted command
- cmd_request  out  1  one-cycle pulse per accepted command
- data_0  out  32  shared data word 0
- data_1  out  32  shared data word 1
- irq  out  1  command-completion interrupt

Behaviour:
- Register map (n64_address[3:2]):
  - 0 = SCR
  - 1 = DATA_0
  - 2 = DATA_1
  - 3 = VERSION (read-only)
- SCR read: {cpu_ready, cpu_busy, irq_pending, cmd_error, cmd_dropped, 19'd0, cmd}.
- Access FSM: IDLE -> WAIT -> ACK -> IDLE.
  - In IDLE with n64_request=1: latch write/address/wdata, load the wait counter with WAIT_STATES.
  - WAIT decrements the counter; WAIT is skipped when WAIT_STATES=0.
  - ACK drives n64_ack=1 for exactly one cycle, then returns to IDLE.
  - Ack latency: WAIT_STATES+1 cycles after the accept cycle.
  - A request still high in the cycle after ACK is treated as a new access.
- Writes:
  - Even halfword: store into hold_hi only; no register changes.
  - Odd halfword: commit {hold_hi, n64_wdata} to the selected register in the ACK cycle.
  - hold_hi is shared across registers and is not cleared on commit.
- SCR commit:
  - If cpu_ready=1, cpu_busy=0 and inflight=0: cmd <= wdata[7:0]; cmd_request pulses in the ACK cycle; inflight <= 1.
  - Otherwise the command is rejected: cmd is unchanged and cmd_dropped <= 1.
  - wdata[27]=1 clears cmd_dropped. If the same commit also rejects the command, set wins.
  - wdata[29]=1 clears irq_pending.
- inflight: cleared on the first cycle cpu_busy=1 is observed. This closes the window before the CPU side raises busy.
- DATA commit:
  - Ignored while cpu_busy=1 or inflight=1.
  - If cpu_data_write[n] is asserted in the same cycle, the CPU write wins and the N64 write is dropped.
  - CPU writes always take effect immediately.
- Reads:
  - Even halfword: snapshot the full selected 32-bit register into rd_latch, record the register index, return [31:16].
  - Odd halfword: return rd_latch[15:0] if the recorded index matches and the latch is valid; otherwise return the live [15:0].
  - An odd read invalidates the latch.
  - Snapshot and rdata are taken in the ACK cycle.
- Reset values: n64_ack=0, n64_rdata=0, cmd=0, cmd_request=0, data_0=0, data_1=0, irq=0. Internal state is cleared: cmd_dropped, irq_pending, inflight, hold_hi, rd_latch valid.
- Reset mid-access: the FSM returns to IDLE and no ack is issued for the aborted request.

Optional Feature:
N64_CFG_IRQ_EN
- Defined:
  - cpu_busy is registered; a 1->0 transition sets irq_pending; irq = irq_pending.
  - If the set event and a clear-by-write coincide, set wins.
- Undefined: irq_pending is constant 0; irq=0; SCR bit 29 reads 0; the clear bit is ignored.

Test Plan:
- Reset, then read VERSION even halfword then odd halfword -> rdata 16'h5343 then 16'h7632; each ack arrives 2 cycles after accept (WAIT_STATES=1).
- cpu_ready=1, cpu_busy=0; write SCR 16'h0000 then 16'h0052 -> cmd=8'h52, one cmd_request pulse. Second command issued before cpu_busy rises -> rejected, SCR bit 27 reads 1.
- Write DATA_0 halves 16'hDEAD and 16'hBEEF with the commit coinciding with cpu_data_write=2'b01, cpu_wdata=32'h12345678 -> data_0=32'h12345678.
- Read DATA_1 even halfword; CPU then writes 32'hAAAA5555; read odd halfword -> returns the pre-write low half (latched value), not 16'h5555.
- With N64_CFG_IRQ_EN: cpu_busy 1->0 -> irq=1. Write SCR with wdata[29]=1 -> irq=0 one cycle after ACK. Without the macro, irq stays 0.
- Assert reset during WAIT -> no n64_ack, all outputs at reset values the cycle after reset.
